// File: rtl/bbox_sample_sequencer.sv
// Bounding-box sample sequencer: accepts a triangle with its bounding box and
// walks the box in raster order (x fastest), one sample per cycle.
module bbox_sample_sequencer #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS-1:0][AXIS-1:0],
  input  logic        [SIGFIG-1:0] color_R13U  [COLORS-1:0],
  input  logic signed [SIGFIG-1:0] box_R13S    [1:0][1:0],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnH,
  output logic signed [SIGFIG-1:0] tri_R14S    [VERTS-1:0][AXIS-1:0],
  output logic        [SIGFIG-1:0] color_R14U  [COLORS-1:0],
  output logic signed [SIGFIG-1:0] sample_R14S [1:0],
  output logic                     validSamp_R14H
);

  typedef enum logic {WAIT, TEST} state_t;

  localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1);

  state_t                   state;
  logic        [SIGFIG-1:0] step;
  logic        [SIGFIG-1:0] step_nxt;
  logic signed [SIGFIG-1:0] ll_x;
  logic signed [SIGFIG-1:0] ur_x;
  logic signed [SIGFIG-1:0] ur_y;

  logic signed [SIGFIG:0]   x_sum;
  logic signed [SIGFIG:0]   y_sum;
  logic                     x_over;
  logic                     y_over;
  logic                     last;
  logic                     accept;
  logic                     degenerate;

  // Anything other than a single legal one-hot code falls back to 1 sample/px.
  always_comb begin
    case (subSample_RnnnnU)
      4'b0100: step_nxt = ONE << (RADIX - 1);
      4'b0010: step_nxt = ONE << (RADIX - 2);
      4'b0001: step_nxt = ONE << (RADIX - 3);
      default: step_nxt = ONE << RADIX;
    endcase
  end

  // One extra bit on the sums keeps the overrun compare from wrapping near the range limit.
  assign x_sum  = $signed({sample_R14S[0][SIGFIG-1], sample_R14S[0]}) + $signed({1'b0, step});
  assign y_sum  = $signed({sample_R14S[1][SIGFIG-1], sample_R14S[1]}) + $signed({1'b0, step});
  assign x_over = x_sum > $signed({ur_x[SIGFIG-1], ur_x});
  assign y_over = y_sum > $signed({ur_y[SIGFIG-1], ur_y});
  assign last   = x_over && y_over;

  assign halt_RnnnnH = (state == TEST) && !last;
  assign accept      = validTri_R13H && !halt_RnnnnH;
  assign degenerate  = (box_R13S[1][0] < box_R13S[0][0]) ||
                       (box_R13S[1][1] < box_R13S[0][1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT;
      validSamp_R14H <= 1'b0;
      sample_R14S    <= '{default: '0};
      tri_R14S       <= '{default: '0};
      color_R14U     <= '{default: '0};
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      step           <= '0;
    end else if (accept) begin
      tri_R14S   <= tri_R13S;
      color_R14U <= color_R13U;
      ll_x       <= box_R13S[0][0];
      ur_x       <= box_R13S[1][0];
      ur_y       <= box_R13S[1][1];
      step       <= step_nxt;
      // An empty box is latched but never iterated, and the last sample stays visible.
      if (degenerate) begin
        state          <= WAIT;
        validSamp_R14H <= 1'b0;
      end else begin
        state          <= TEST;
        validSamp_R14H <= 1'b1;
        sample_R14S[0] <= box_R13S[0][0];
        sample_R14S[1] <= box_R13S[0][1];
      end
    end else if (state == TEST) begin
      if (last) begin
        state          <= WAIT;
        validSamp_R14H <= 1'b0;
      end else begin
        validSamp_R14H <= 1'b1;
        if (x_over) begin
          sample_R14S[0] <= ll_x;
          sample_R14S[1] <= y_sum[SIGFIG-1:0];
        end else begin
          sample_R14S[0] <= x_sum[SIGFIG-1:0];
        end
      end
    end else begin
      validSamp_R14H <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bbox_sample_sequencer.sv
// Self-checking bench for bbox_sample_sequencer: a queue-based model of the
// expected sample stream, directed boundary cases, then randomized traffic.
module tb_bbox_sample_sequencer;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_in   [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] col_in   [COLORS-1:0];
  logic signed [SIGFIG-1:0] box_in   [1:0][1:0];
  logic                     validTri;
  logic        [3:0]        sub_in;
  logic                     halt;
  logic signed [SIGFIG-1:0] tri_o    [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] col_o    [COLORS-1:0];
  logic signed [SIGFIG-1:0] sample_o [1:0];
  logic                     validSamp;

  always #5 clk = ~clk;

  bbox_sample_sequencer #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tri_R13S(tri_in),
    .color_R13U(col_in),
    .box_R13S(box_in),
    .validTri_R13H(validTri),
    .subSample_RnnnnU(sub_in),
    .halt_RnnnnH(halt),
    .tri_R14S(tri_o),
    .color_R14U(col_o),
    .sample_R14S(sample_o),
    .validSamp_R14H(validSamp)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model: queue of samples still to be shown, head = sample on the outputs now.
  longint qx[$];
  longint qy[$];
  logic signed [SIGFIG-1:0] exp_tri [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] exp_col [COLORS-1:0];
  longint exp_sx = 0;
  longint exp_sy = 0;
  bit     last_acc = 1'b0;

  bit     lv[$];
  bit     lh[$];
  longint lx[$];
  longint ly[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint model_step(input logic [3:0] s);
    longint base;
    base = longint'(1) << RADIX;
    case (s)
      4'b0100: return base / 2;
      4'b0010: return base / 4;
      4'b0001: return base / 8;
      default: return base;
    endcase
  endfunction

  task automatic clear_log();
    lv.delete(); lh.delete(); lx.delete(); ly.delete();
  endtask

  function automatic int count_valid();
    int n = 0;
    foreach (lv[i]) if (lv[i]) n++;
    return n;
  endfunction

  task automatic set_box(input int llx, input int lly, input int urx, input int ury);
    box_in[0][0] = SIGFIG'(llx);
    box_in[0][1] = SIGFIG'(lly);
    box_in[1][0] = SIGFIG'(urx);
    box_in[1][1] = SIGFIG'(ury);
  endtask

  task automatic rand_data();
    for (int i = 0; i < VERTS; i++)
      for (int j = 0; j < AXIS; j++) tri_in[i][j] = SIGFIG'($urandom);
    for (int i = 0; i < COLORS; i++) col_in[i] = SIGFIG'($urandom);
  endtask

  // One clock: drive, advance model at the edge, compare #1 later.
  task automatic cyc(input bit r, input bit v);
    bit     acc;
    longint st;
    rst      = r;
    validTri = v;
    acc = v && !r && (qx.size() <= 1);
    @(posedge clk);
    if (r) begin
      qx.delete(); qy.delete();
      exp_sx  = 0;
      exp_sy  = 0;
      exp_tri = '{default: '0};
      exp_col = '{default: '0};
    end else if (acc) begin
      exp_tri = tri_in;
      exp_col = col_in;
      st = model_step(sub_in);
      qx.delete(); qy.delete();
      for (longint y = box_in[0][1]; y <= box_in[1][1]; y += st)
        for (longint x = box_in[0][0]; x <= box_in[1][0]; x += st) begin
          qx.push_back(x);
          qy.push_back(y);
        end
    end else if (qx.size() > 0) begin
      void'(qx.pop_front());
      void'(qy.pop_front());
    end
    if (qx.size() > 0) begin
      exp_sx = qx[0];
      exp_sy = qy[0];
    end
    last_acc = acc;
    #1;
    chk("validSamp", longint'(validSamp), longint'(qx.size() > 0));
    chk("halt", longint'(halt), longint'(qx.size() > 1));
    chk("sample_x", longint'(sample_o[0]), exp_sx);
    chk("sample_y", longint'(sample_o[1]), exp_sy);
    for (int i = 0; i < VERTS; i++)
      for (int j = 0; j < AXIS; j++)
        chk("tri", longint'(tri_o[i][j]), longint'(exp_tri[i][j]));
    for (int i = 0; i < COLORS; i++)
      chk("color", longint'(col_o[i]), longint'(exp_col[i]));
    lv.push_back(validSamp);
    lh.push_back(halt);
    lx.push_back(longint'(sample_o[0]));
    ly.push_back(longint'(sample_o[1]));
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && qx.size() > 0; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("drain_bound", longint'(qx.size()), 0);
  endtask

  longint lit_x [6] = '{0, 1024, 2048, 0, 1024, 2048};
  longint lit_y [6] = '{0, 0, 0, 1024, 1024, 1024};
  bit     cur_v;
  int     llx, lly, w, h;

  initial begin
    rst = 1'b1; validTri = 1'b0; sub_in = 4'b1000;
    tri_in = '{default: '0}; col_in = '{default: '0}; box_in = '{default: '0};
    exp_tri = '{default: '0}; exp_col = '{default: '0};
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);

    // Basic 6-sample raster at 1 sample/px
    clear_log(); rand_data(); set_box(0, 0, 2048, 1024); sub_in = 4'b1000;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("r037_valid", longint'(lv[i]), 1);
      chk("r037_x", lx[i], lit_x[i]);
      chk("r037_y", ly[i], lit_y[i]);
      chk("r037_halt", longint'(lh[i]), longint'(i < 5));
    end
    chk("r037_wait", longint'(lv[6]), 0);
    drain();

    // 4 samples/px over the same box
    clear_log(); rand_data(); sub_in = 4'b0100;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
    chk("r038_count", count_valid(), 15);
    chk("r038_first_x", lx[0], 0);
    chk("r038_first_y", ly[0], 0);
    chk("r038_last_x", lx[14], 2048);
    chk("r038_last_y", ly[14], 1024);
    drain();

    // Back-to-back with the second triangle held valid
    clear_log(); rand_data(); sub_in = 4'b1000;
    cyc(1'b0, 1'b1);
    rand_data(); set_box(4096, 4096, 4096, 4096);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("r039_valid", longint'(lv[6]), 1);
    chk("r039_x", lx[6], 4096);
    chk("r039_y", ly[6], 4096);
    chk("r039_halt", longint'(lh[6]), 0);
    chk("r039_after", longint'(lv[7]), 0);
    chk("r039_count", count_valid(), 7);
    drain();

    // Degenerate box then an immediate follow-on triangle
    clear_log(); rand_data(); set_box(1024, 0, 0, 0);
    cyc(1'b0, 1'b1);
    rand_data(); set_box(100, 200, 100, 200);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("r040_noval", longint'(lv[0]), 0);
    chk("r040_nohalt", longint'(lh[0]), 0);
    chk("r040_next_valid", longint'(lv[1]), 1);
    chk("r040_next_x", lx[1], 100);
    chk("r040_next_y", ly[1], 200);
    drain();

    // Reset on the third sample, then a fresh triangle
    clear_log(); rand_data(); set_box(0, 0, 2048, 1024);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("r041_third_x", lx[2], 2048);
    cyc(1'b1, 1'b1);
    chk("r041_rst_valid", longint'(lv[3]), 0);
    chk("r041_rst_halt", longint'(lh[3]), 0);
    chk("r041_rst_x", lx[3], 0);
    rand_data(); set_box(-300, 50, 724, 50);
    cyc(1'b0, 1'b1);
    chk("r041_fresh_x", lx[4], -300);
    chk("r041_fresh_y", ly[4], 50);
    drain();

    // Illegal rate code and a rate change mid-triangle
    clear_log(); rand_data(); set_box(0, 0, 2048, 1024); sub_in = 4'b0110;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    chk("r042_illegal_count", count_valid(), 6);
    chk("r042_illegal_x1", lx[1], 1024);
    clear_log(); rand_data(); sub_in = 4'b1000;
    cyc(1'b0, 1'b1);
    sub_in = 4'b0001;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    chk("r042_change_count", count_valid(), 6);
    drain();

    // Randomized traffic; a refused triangle is held unchanged until taken
    cur_v = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!(cur_v && !last_acc)) begin
        cur_v = ($urandom_range(0, 9) < 6);
        if (cur_v) begin
          rand_data();
          llx = int'($urandom_range(0, 8000)) - 4000;
          lly = int'($urandom_range(0, 8000)) - 4000;
          w   = int'($urandom_range(0, 2100));
          h   = int'($urandom_range(0, 1500));
          if ($urandom_range(0, 15) == 0) w = -int'($urandom_range(1, 500));
          if ($urandom_range(0, 15) == 0) h = -int'($urandom_range(1, 500));
          set_box(llx, lly, llx + w, lly + h);
        end
      end
      if ($urandom_range(0, 3) == 0) sub_in = 4'($urandom_range(0, 15));
      else sub_in = 4'b1000 >> $urandom_range(0, 3);
      cyc(($urandom_range(0, 299) == 0), cur_v);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bbox_sample_sequencer.md
BBOX_SAMPLE_SEQUENCER -- requirements
Module: bbox_sample_sequencer

Interface
REQ-001 Parameters SHALL be: SIGFIG, default 24, bits per coordinate/color; RADIX, default 10, fraction bits; VERTS, default 3, vertices per triangle; AXIS, default 3, axes per vertex (x,y,z); COLORS, default 3, color channels.
REQ-002 clk  input  1  clock; the block SHALL use one clock.
REQ-003 rst  input  1  reset; reset SHALL be synchronous and active-high.
REQ-004 tri_R13S  input  signed [SIGFIG-1:0] x VERTS x AXIS  triangle vertices.
REQ-005 color_R13U  input  unsigned [SIGFIG-1:0] x COLORS  triangle color.
REQ-006 box_R13S  input  signed [SIGFIG-1:0] x 2 x 2  bounding box; [0]=LL(x,y), [1]=UR(x,y), inclusive.
REQ-007 validTri_R13H  input  1  triangle/box valid.
REQ-008 subSample_RnnnnU  input  4  one-hot sample rate: 1000=1/px, 0100=4/px, 0010=16/px, 0001=64/px.
REQ-009 halt_RnnnnH  output  1  high = upstream held; the triangle is not accepted.
REQ-010 tri_R14S, color_R14U  output  same shapes as inputs  latched triangle and color for the sample test.
REQ-011 sample_R14S  output  signed [SIGFIG-1:0] x 2  current sample (x,y).
REQ-012 validSamp_R14H  output  1  sample_R14S is valid this cycle.

Function
REQ-013 FSM SHALL have two states, WAIT and TEST; the state register resets to WAIT.
REQ-014 Accept: a triangle SHALL be accepted on a rising clk edge where validTri_R13H=1 and halt_RnnnnH=0.
REQ-015 validTri_R13H while halt_RnnnnH=1 SHALL be ignored; upstream holds its data.
REQ-016 On accept, the block SHALL latch tri, color, box and the step.
REQ-017 Step = 1<<(RADIX-k), with k=0,1,2,3 for rates 1000,0100,0010,0001.
REQ-018 A non-one-hot or zero subSample SHALL be treated as 1000 (k=0).
REQ-019 Later subSample changes SHALL NOT affect the triangle in progress.
REQ-020 Latency: the cycle after accept SHALL show state=TEST, validSamp_R14H=1, sample_R14S=LL.
REQ-021 Each TEST cycle SHALL output exactly one sample; samples SHALL advance in raster order, x fastest.
REQ-022 Advance rule: if x+step > UR.x, then x<=LL.x and y<=y+step; otherwise x<=x+step.
REQ-023 Last sample: the current sample SHALL be last when (x+step > UR.x) and (y+step > UR.y).
REQ-024 The sum x+step and the y equivalent SHALL be computed at SIGFIG+1 bits signed, so the compare never wraps.
REQ-025 halt_RnnnnH SHALL equal (state==TEST) && !last; it is combinational from registers only.
REQ-026 On the last-sample cycle, the FSM SHALL go to WAIT when no accept occurs.
REQ-027 On the last-sample cycle with a simultaneous accept, the next cycle SHALL be TEST at the new LL, with no bubble.
REQ-028 Degenerate box (UR.x<LL.x or UR.y<LL.y) at accept SHALL emit zero samples: state stays WAIT, validSamp_R14H=0, halt_RnnnnH stays 0.
REQ-029 A single-sample box (LL==UR) SHALL emit one sample, with halt_RnnnnH=0 in that cycle.
REQ-030 Boxes are not snapped: iteration SHALL start at LL exactly as given.
REQ-031 The sample count per triangle SHALL be (floor((UR.x-LL.x)/step)+1) * (floor((UR.y-LL.y)/step)+1).
REQ-032 In WAIT with no accept, validSamp_R14H SHALL be 0, and tri/color/sample SHALL hold their last values.
REQ-033 Z and color SHALL pass through unmodified; the block does no coverage test.

Reset
REQ-034 When rst=1 at a clk edge, the next-cycle values SHALL be: state=WAIT, validSamp_R14H=0, halt_RnnnnH=0, and sample_R14S, tri_R14S, color_R14U, latched box and step all 0.
REQ-035 rst SHALL take priority over accept; validTri_R13H in a reset cycle is dropped.
REQ-036 Reset mid-triangle SHALL abort the iteration; no further samples are emitted for that triangle.

Verification
REQ-037 RADIX=10, rate 1000, box LL=(0,0), UR=(2048,1024) -> samples over 6 consecutive cycles: (0,0), (1024,0), (2048,0), (0,1024), (1024,1024), (2048,1024); halt 1,1,1,1,1,0; then WAIT.
REQ-038 Same box, rate 0100 -> 15 samples with step 512; first (0,0), last (2048,1024).
REQ-039 Back-to-back: second triangle held valid during the first; box2 LL=(4096,4096) -> cycle after the last sample of triangle 1 shows sample (4096,4096) with validSamp=1 and no idle cycle.
REQ-040 Degenerate box LL=(1024,0), UR=(0,0) -> no validSamp pulse, halt stays 0, and the next triangle is accepted the following cycle.
REQ-041 Reset asserted on the 3rd sample of REQ-037 -> next cycle validSamp=0, halt=0, outputs 0; a fresh triangle afterwards restarts at its LL.
REQ-042 subSample=0110 (illegal) -> treated as 1000; subSample changed mid-triangle -> the step is unchanged until the next accept.
